mips_mdu: RTL and testbench
===========================

MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are 4 or more.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  WIDTH  multiplicand or dividend (rs), captured with start.
REQ-007 b  input  WIDTH  multiplier or divisor (rt), captured with start.
REQ-008 flush  input  1  cancels the in-flight operation (pipeline flush).
REQ-009 mthi  input  1  write wdata into HI.
REQ-010 mtlo  input  1  write wdata into LO.
REQ-011 wdata  input  WIDTH  data for mthi/mtlo.
REQ-012 busy  output  1  operation in flight; the pipeline stalls MFHI/MFLO and new MDU operations while this is high.
REQ-013 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-014 div_by_zero  output  1  one-cycle pulse coincident with done when the divisor was zero.
REQ-015 hi  output  WIDTH  HI register.
REQ-016 lo  output  WIDTH  LO register.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FIX, with busy = (state != IDLE).
- IDLE to RUN when start=1: a, b and op are captured, and the iteration counter is loaded with WIDTH.
- RUN lasts exactly WIDTH cycles, with one shift-add or one restoring-subtract step per cycle on operand magnitudes.
- RUN to FIX when the counter reaches 0.
- FIX to IDLE after one cycle.
REQ-018 The edge leaving FIX SHALL load hi/lo, assert done for one cycle and deassert busy, so done is high WIDTH+1 cycles after the start edge (33 cycles for WIDTH=32).
REQ-019 MULT/MULTU SHALL produce {hi,lo} = 2*WIDTH-bit product; for MULT, operands are signed two's complement, and FIX negates the magnitude product when the operand signs differ.
REQ-020 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
- FIX applies the sign corrections.
REQ-021 Division with b=0 SHALL still take the full latency, and yield hi=a, lo=all ones, div_by_zero=1 with done.
REQ-022 DIV of the most-negative value by -1 SHALL yield lo = most-negative value (wrap) and hi=0, with no flag.
REQ-023 start while busy SHALL be ignored; no queueing.
REQ-024 mthi/mtlo SHALL update hi/lo on the next edge only while IDLE and start=0.
- While busy, they are ignored.
- When start=1 in the same IDLE cycle, start wins and they are ignored.
REQ-025 mthi and mtlo together SHALL write wdata to both registers.
REQ-026 flush while busy SHALL return the FSM to IDLE on the next edge.
- hi/lo are unchanged.
- No done or div_by_zero pulse is produced.
REQ-027 flush coincident with start in IDLE SHALL suppress the start.
REQ-028 flush asserted during FIX SHALL win: no result is written.
REQ-029 hi/lo SHALL change only on mthi/mtlo, on FIX completion, or on reset.

Reset
REQ-030 While reset=0, state SHALL be IDLE, and busy, done, div_by_zero, hi, lo and the counter SHALL be 0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release, the block accepts start on the first rising edge.

Verification
REQ-032 Bench scenarios, WIDTH=32:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done on the 33rd edge after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0 -> hi=0x00000005, lo=0xFFFFFFFF, div_by_zero=1 for exactly one cycle with done. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- mthi wdata=0x1234 then MULTU 2*3 with flush at cycle 10 -> no done; hi=0x1234 retained; busy low one edge after flush; a new start is accepted next.
- start and mtlo in the same IDLE cycle -> mtlo ignored. start while busy -> ignored, and only one done is produced.
- reset pulsed low mid-RUN -> hi=lo=0 and busy=0 immediately without a clock; a DIVU 100/7 after release -> lo=14, hi=2.

Source files
------------

// File: rtl/mips_mdu_if.sv
// mips_mdu_if -- bundle of request, response and HI/LO signals for the
// multiply/divide unit.
//   master (pipeline side): drives start, op, a, b, flush, mthi, mtlo, wdata;
//                           observes busy, done, div_by_zero, hi, lo.
//   slave  (MDU side):      the mirror image of master.
interface mips_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, mthi, mtlo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_mdu.sv
// mips_mdu -- iterative MIPS multiply/divide unit with HI/LO registers.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mips_mdu_if.slave
//           start/op/a/b  launch MULTU(00) MULT(01) DIVU(10) DIV(11)
//           flush         cancel the in-flight operation
//           mthi/mtlo     write wdata into HI/LO while idle
//           busy          operation in flight
//           done          one-cycle pulse when HI/LO take a result
//           div_by_zero   one-cycle pulse with done for a zero divisor
//           hi/lo         architectural HI and LO registers
// Works on operand magnitudes for WIDTH cycles (shift-add or restoring
// subtract), then applies the sign fix-ups in a single FIX cycle.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mips_mdu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic             accept, step, commit, write_en;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Only the signed operations (op[0]) treat the top bit as a sign.
  assign a_neg    = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg    = bus.op[0] & bus.b[WIDTH-1];
  assign mag_a_in = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign mag_b_in = b_neg ? (~bus.b + 1'b1) : bus.b;

  // One multiply step: conditionally add the multiplicand into the upper
  // half, then shift the whole product right, pulling the carry in.
  assign mul_sum   = {1'b0, p_hi} + {1'b0, (p_lo[0] ? mag_b_q : '0)};

  // One restoring-divide step: p_hi is the partial remainder, p_lo shifts
  // the dividend out at the top and the quotient bits in at the bottom.
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_ge    = (div_shift >= {1'b0, mag_b_q});

  // Sign fix-ups applied when leaving FIX. A zero divisor leaves the
  // dividend magnitude in p_hi, so restoring its sign gives back a.
  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_res_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_res_q ? (~p_lo + 1'b1) : p_lo;
  assign rem_fix  = neg_rem_q ? (~p_hi + 1'b1) : p_hi;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = div0_q ? '1 : quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath controls. Flush beats start in IDLE and beats
  // the result write in FIX; mthi/mtlo only act in an idle cycle without start.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    write_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.flush) begin
            accept     = 1'b1;
            state_next = RUN;
          end
        end else if (bus.mthi || bus.mtlo) begin
          write_en = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CW'(1)) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        commit     = !bus.flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, HI/LO update and result pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mag_b_q   <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= commit;
      dbz_q  <= commit & div0_q;
      if (accept) begin
        cnt       <= CW'(WIDTH);
        is_div_q  <= bus.op[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= bus.op[1] & (bus.b == '0);
        mag_b_q   <= mag_b_in;
        p_hi      <= '0;
        p_lo      <= mag_a_in;
      end else if (step) begin
        cnt <= cnt - 1'b1;
        if (is_div_q) begin
          p_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], div_ge};
        end else begin
          p_hi <= mul_sum[WIDTH:1];
          p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
        end
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (write_en) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu -- directed bench for mips_mdu at WIDTH=32. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mips_mdu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_mdu_if #(.WIDTH(32)) bus();

  mips_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Launch an operation and wait (bounded) for done. edges counts rising
  // edges after the start edge; busy_cycles counts sampled busy-high cycles.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int edges, output int busy_cycles, output logic dbz, output logic timed_out);
    bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0; busy_cycles = 0;
    while (!bus.done && edges < 200) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
    timed_out = !bus.done;
    dbz = bus.div_by_zero;
  endtask

  // Single idle-cycle HI/LO write.
  task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
    bus.mthi = h; bus.mtlo = l; bus.wdata = d;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero}); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_multu();
    int e, bc; logic z, t;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL multu_timeout: done never seen"); end
    checks++; if (e !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected %0d", e, 33); end
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected %0d", bc, 33); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", bus.hi, 32'hFFFFFFFE); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", bus.lo, 32'h1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_busy_at_done: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_mult();
    int e, bc; logic z, t;
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL mult_timeout: done never seen"); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h expected %h", bus.lo, 32'hFFFFFFEB); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int e, bc; logic z, t;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL div_timeout: done never seen"); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected %h", bus.lo, 32'hFFFFFFFD); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL div_flag: got %b expected 0", z); end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int e, bc; logic z, t;
    run_op(2'b10, 32'd5, 32'd0, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL dbz_timeout: done never seen"); end
    checks++; if (e !== 33) begin errors++; $display("[TB] FAIL dbz_latency: got %0d expected %0d", e, 33); end
    checks++; if (bus.hi !== 32'h5) begin errors++; $display("[TB] FAIL dbz_hi: got %h expected %h", bus.hi, 32'h5); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL dbz_lo: got %h expected %h", bus.lo, 32'hFFFFFFFF); end
    checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b expected 1", z); end
    @(negedge clk);
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL dbz_flag_pulse: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_div_overflow();
    int e, bc; logic z, t;
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL divovf_timeout: done never seen"); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL divovf_lo: got %h expected %h", bus.lo, 32'h80000000); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL divovf_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL divovf_flag: got %b expected 0", z); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(1'b1, 1'b1, 32'hCAFEF00D);
    checks++; if (bus.hi !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL both_hi: got %h expected %h", bus.hi, 32'hCAFEF00D); end
    checks++; if (bus.lo !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL both_lo: got %h expected %h", bus.lo, 32'hCAFEF00D); end
  endtask

  task automatic test_flush();
    int e, bc, seen; logic z, t;
    write_hilo(1'b1, 1'b0, 32'h1234);
    write_hilo(1'b0, 1'b1, 32'h5555);
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("[TB] FAIL flush_mthi: got %h expected %h", bus.hi, 32'h1234); end
    bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.div_by_zero) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d pulses expected 0", seen); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("[TB] FAIL flush_hi: got %h expected %h", bus.hi, 32'h1234); end
    checks++; if (bus.lo !== 32'h5555) begin errors++; $display("[TB] FAIL flush_lo: got %h expected %h", bus.lo, 32'h5555); end
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_suppress: got %b expected 0", bus.busy); end
    run_op(2'b00, 32'd2, 32'd3, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL flush_restart_timeout: done never seen"); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("[TB] FAIL flush_restart_lo: got %h expected %h", bus.lo, 32'd6); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL flush_restart_hi: got %h expected %h", bus.hi, 32'd0); end
    @(negedge clk);
  endtask

  task automatic test_flush_fix();
    int seen;
    write_hilo(1'b1, 1'b1, 32'h11111111);
    bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (32) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL fixflush_busy_before: got %b expected 1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL fixflush_no_done: got %0d pulses expected 0", seen); end
    checks++; if (bus.lo !== 32'h11111111) begin errors++; $display("[TB] FAIL fixflush_lo: got %h expected %h", bus.lo, 32'h11111111); end
  endtask

  task automatic test_start_mtlo();
    int e, bc; logic z, t;
    write_hilo(1'b0, 1'b1, 32'h77);
    bus.mtlo = 1'b1; bus.wdata = 32'hDEAD;
    run_op(2'b00, 32'd4, 32'd5, e, bc, z, t);
    bus.mtlo = 1'b0;
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL startmtlo_timeout: done never seen"); end
    checks++; if (bus.lo !== 32'd20) begin errors++; $display("[TB] FAIL startmtlo_lo: got %h expected %h", bus.lo, 32'd20); end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int edges, seen;
    bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    repeat (4) begin @(negedge clk); edges++; end
    bus.a = 32'd100; bus.b = 32'd100; bus.start = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'hBAD;
    @(negedge clk); edges++;
    bus.start = 1'b0; bus.mthi = 1'b0;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL busy_mthi_ignored: got %h expected %h", bus.hi, 32'd0); end
    while (!bus.done && edges < 200) begin @(negedge clk); edges++; end
    checks++; if (edges !== 33) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", edges, 33); end
    checks++; if (bus.lo !== 32'd9) begin errors++; $display("[TB] FAIL busy_lo: got %h expected %h", bus.lo, 32'd9); end
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL busy_single_done: got %0d extra expected 0", seen); end
  endtask

  task automatic test_reset_mid_run();
    int e, bc; logic z, t;
    write_hilo(1'b1, 1'b1, 32'h5A5A5A5A);
    bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL midreset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b10, 32'd100, 32'd7, e, bc, z, t);
    checks++; if (t !== 1'b0) begin errors++; $display("[TB] FAIL midreset_timeout: done never seen"); end
    checks++; if (e !== 33) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", e, 33); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL midreset_lo_q: got %h expected %h", bus.lo, 32'd14); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL midreset_hi_r: got %h expected %h", bus.hi, 32'd2); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_div_overflow();
    test_mthi_mtlo();
    test_flush();
    test_flush_fix();
    test_start_mtlo();
    test_start_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
